// File: rtl/conv_pkg.sv
// Shared widths and FSM state type for the convolution MAC front end.
// Sized so that a full-scale 3x3 sum never overflows numer or denom.
package conv_pkg;
    localparam int PIX_W   = 8;
    localparam int COEF_W  = 11;
    localparam int NUMER_W = 23;
    localparam int DENOM_W = 15;
    localparam int TAPS    = 9;
    localparam int PROD_W  = PIX_W + COEF_W;
    localparam int TAP_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;
endpackage

// File: rtl/conv_mac_accum_valid_delay_line.sv
// Fixed-depth shift register that realigns valid/flag bits with the divider output.
// Shifts every cycle; the asynchronous clear flushes any bits in flight.
module valid_delay_line #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clock or negedge aclr_n) begin
                    if (!aclr_n) stage_reg[gi] <= '0;
                    else         stage_reg[gi] <= din;
                end
            end else begin : g_body
                always_ff @(posedge clock or negedge aclr_n) begin
                    if (!aclr_n) stage_reg[gi] <= '0;
                    else         stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign dout = stage_reg[DEPTH-1];
endmodule

// File: rtl/conv_mac_accum.sv
// Serial 3x3 multiply-accumulate feeding a pipelined divider: one tap per cycle,
// denom forced non-zero, and a valid strobe delayed to match the quotient.
module conv_mac_accum
    import conv_pkg::*;
#(
    parameter int DIV_LATENCY = 6,
    parameter int TAPS        = 9
) (
    input  logic                     clock,
    input  logic                     aclr_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAPS*PIX_W-1:0]    in_pixels,
    input  logic                     coef_wr,
    output logic                     coef_ready,
    input  logic [TAP_W-1:0]         coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic [NUMER_W-1:0]       numer,
    output logic [DENOM_W-1:0]       denom,
    output logic                     out_valid,
    output logic                     zero_sum,
    output logic                     quot_valid,
    output logic                     quot_zero_sum
);
    state_t                 state_reg, state_next;
    logic [TAP_W-1:0]       tap_reg;
    logic [TAPS*PIX_W-1:0]  window_reg;
    logic [COEF_W-1:0]      coef_reg [TAPS];
    logic [PIX_W-1:0]       pix_arr  [TAPS];
    logic [NUMER_W-1:0]     acc_reg, acc_next, numer_reg;
    logic [DENOM_W-1:0]     csum_reg, csum_next, denom_reg;
    logic                   out_valid_reg, zero_sum_reg;
    logic                   accept, last_tap, coef_we;
    logic [PIX_W-1:0]       pix_sel;
    logic [COEF_W-1:0]      coef_sel;
    logic [PROD_W-1:0]      prod;
    logic [1:0]             delay_out;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last_tap   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (tap_reg == TAP_W'(TAPS - 1)) begin
                    last_tap   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready   = (state_reg == IDLE);
    assign coef_ready = (state_reg == IDLE);
    assign coef_we    = coef_wr && coef_ready;

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            assign pix_arr[gi] = window_reg[gi*PIX_W +: PIX_W];

            // Addresses beyond the last tap match no entry and are silently dropped.
            always_ff @(posedge clock or negedge aclr_n) begin
                if (!aclr_n)
                    coef_reg[gi] <= '0;
                else if (coef_we && coef_addr == TAP_W'(gi))
                    coef_reg[gi] <= coef_data;
            end
        end
    endgenerate

    assign pix_sel   = pix_arr[tap_reg];
    assign coef_sel  = coef_reg[tap_reg];
    assign prod      = pix_sel * coef_sel;
    assign acc_next  = acc_reg + NUMER_W'(prod);
    assign csum_next = csum_reg + DENOM_W'(coef_sel);

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            window_reg    <= '0;
            tap_reg       <= '0;
            acc_reg       <= '0;
            csum_reg      <= '0;
            numer_reg     <= '0;
            denom_reg     <= DENOM_W'(1);
            zero_sum_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= last_tap;
            if (accept) begin
                window_reg <= in_pixels;
                tap_reg    <= '0;
                acc_reg    <= '0;
                csum_reg   <= '0;
            end else if (state_reg == ACCUM) begin
                tap_reg  <= tap_reg + TAP_W'(1);
                acc_reg  <= acc_next;
                csum_reg <= csum_next;
                if (last_tap) begin
                    numer_reg    <= acc_next;
                    // A zero denominator would stall the divider pipeline.
                    denom_reg    <= (csum_next == '0) ? DENOM_W'(1) : csum_next;
                    zero_sum_reg <= (csum_next == '0);
                end
            end
        end
    end

    valid_delay_line #(
        .DEPTH (DIV_LATENCY),
        .WIDTH (2)
    ) u_delay (
        .clock  (clock),
        .aclr_n (aclr_n),
        .din    ({zero_sum_reg, out_valid_reg}),
        .dout   (delay_out)
    );

    assign numer         = numer_reg;
    assign denom         = denom_reg;
    assign out_valid     = out_valid_reg;
    assign zero_sum      = zero_sum_reg;
    assign quot_valid    = delay_out[0];
    assign quot_zero_sum = delay_out[1];
endmodule
